rf_multiport_sb: RTL and testbench
==================================

Name: rf_multiport_sb

Overview:
- Parametrised successor to the single-write 2-read pipeline register file.
- Configurable data width, register count and read-port count.
- Two write ports: port 0 from ALU writeback, port 1 from memory/load writeback.
- Integrated pending-write scoreboard for decode-stage hazard detection; sits between the decode and writeback stages of the ARMv8 pipeline.

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, $clog2(NUM_REGS), register index width; derived, not overridden.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 31, index hardwired to zero (XZR).

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-low.
- RAddr  in  NUM_RD*ADDR_W  packed read indices; port k is bits [k*ADDR_W +: ADDR_W].
- RData  out  NUM_RD*DATA_W  packed read data.
- RPend  out  NUM_RD  1 = the read register has an outstanding allocated write.
- WE0  in  1  write enable, port 0 (ALU).
- WAddr0  in  ADDR_W  write index, port 0.
- WData0  in  DATA_W  write data, port 0.
- WE1  in  1  write enable, port 1 (load).
- WAddr1  in  ADDR_W  write index, port 1.
- WData1  in  DATA_W  write data, port 1.
- AllocEn  in  1  issue marks a destination as pending.
- AllocAddr  in  ADDR_W  destination index to mark.
- PendVec  out  NUM_REGS  full scoreboard, registered.
- WrConflict  out  1  registered pulse: both write ports hit the same non-zero index.

Behaviour:
- Reset (Rst==0 at posedge):
  - All registers, PendVec and WrConflict clear to 0.
  - Reset dominates writes and allocs in the same cycle.
  - Reset mid-operation discards all pending state.
- Reads:
  - Combinational, no added delay.
  - RData_k = regs[RAddr_k]; RPend_k = PendVec[RAddr_k].
- Writes:
  - Take effect at posedge when the enable is high; visible to reads in the following cycle.
  - Same index on both ports: port 1 (load) wins, and WrConflict = 1 for exactly the next cycle.
  - Otherwise WrConflict = 0.
- Zero register:
  - Writes and allocs to ZERO_REG are ignored.
  - Reads return 0 with RPend = 0; PendVec[ZERO_REG] is always 0.
  - No WrConflict is raised for ZERO_REG.
- Out-of-range index (>= NUM_REGS):
  - Write and alloc ignored.
  - Read returns 0, RPend = 0.
- Scoreboard, per-register bit:
  - Set at posedge on AllocEn && AllocAddr==i.
  - Cleared at posedge on (WE0 && WAddr0==i) or (WE1 && WAddr1==i).
  - Alloc and write to the same index in the same cycle: set wins (a new producer supersedes).
  - Alloc to an already-pending register: stays 1.
  - A write to a non-pending register is legal; bit stays 0.
- No stall or handshake: the decode stage consumes RPend and stalls externally.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding: if WEx && WAddrx==RAddr_k (non-zero, in range), RData_k = WDatax, with port 1 priority.
  - RPend_k = 0 for that read, unless AllocEn targets the same index in that cycle.
  - Zero-cycle write-read latency.
- Undefined:
  - Reads see the pre-write value; RPend_k reflects the stored bit only.
  - Write-read latency is 1 cycle.

Decomposition:
- Package rf_pkg holds:
  - Default DATA_W, NUM_REGS and ZERO_REG constants.
  - reg_idx_t (ADDR_W-bit index typedef).
  - A wb_port_t struct {we, addr, data} used for both write ports.
- Sub-module rf_read_port, instantiated NUM_RD times via generate:
  - Index mux, zero/out-of-range masking, pending lookup.
  - Bypass compare under RF_BYPASS_EN.
- Storage, write arbitration, scoreboard and WrConflict stay in the top module.

Test Plan:
- Reset: hold Rst=0 one cycle after random writes -> every RData = 0, PendVec = 0, WrConflict = 0.
- Write then read: WE0=1, WAddr0=5, WData0=64'hDEAD_BEEF -> next cycle RAddr0=5 gives 64'hDEAD_BEEF; without the macro, the same-cycle read gives the old value 0.
- Zero register: WE1=1, WAddr1=31, WData1=64'hFFFF; AllocEn=1, AllocAddr=31 -> RData=0, RPend=0, PendVec[31]=0.
- Write conflict: WE0=WE1=1, both WAddr=7, WData0=1, WData1=2 -> reg7=2, WrConflict=1 for one cycle then 0.
- Scoreboard: alloc 3 -> PendVec[3]=1, RPend=1 on a read of 3; WE1 write to 3 -> bit clears; same-cycle alloc 3 + WE0 write 3 -> bit stays 1.
- Bypass (RF_BYPASS_EN): WE0=1, WAddr0=9, WData0=64'h1234 with RAddr1=9 in the same cycle -> RData1=64'h1234, RPend1=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file with pending-write scoreboard.
package rf_pkg;

  localparam int RF_DATA_W   = 64;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ZERO_REG = 31;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic                 we;
    reg_idx_t             addr;
    logic [RF_DATA_W-1:0] data;
  } wb_port_t;

  // An index that names real, writable storage: in range and not the hardwired zero register.
  function automatic logic idx_live(input int idx, input int num_regs, input int zero_reg);
    return (idx >= 0) && (idx < num_regs) && (idx != zero_reg);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: index mux, zero/out-of-range masking and pending lookup.
// With RF_BYPASS_EN defined, same-cycle writes are forwarded to the read.
module rf_read_port
  import rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int ZERO_REG = RF_ZERO_REG,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  logic [NUM_REGS-1:0] pend_i,
`ifdef RF_BYPASS_EN
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
`endif
  output logic [DATA_W-1:0] rdata_o,
  output logic              rpend_o
);

  logic              live_s;
  logic [DATA_W-1:0] stored_data_s;
  logic              stored_pend_s;

  // Stored value and pending bit, masked to zero for XZR and unmapped indices.
  always_comb begin
    live_s        = idx_live(int'(raddr_i), NUM_REGS, ZERO_REG);
    stored_data_s = live_s ? regs_i[raddr_i] : {DATA_W{1'b0}};
    stored_pend_s = live_s ? pend_i[raddr_i] : 1'b0;
  end

`ifdef RF_BYPASS_EN
  logic fwd0_s;
  logic fwd1_s;

  // Forward a same-cycle write; the load port wins, and a fresh alloc keeps the read pending.
  always_comb begin
    fwd0_s  = live_s && we0_i && (waddr0_i == raddr_i);
    fwd1_s  = live_s && we1_i && (waddr1_i == raddr_i);
    rdata_o = fwd1_s ? wdata1_i : (fwd0_s ? wdata0_i : stored_data_s);
    rpend_o = (fwd0_s || fwd1_s) ? (alloc_en_i && (alloc_addr_i == raddr_i)) : stored_pend_s;
  end
`else
  // Reads see only the stored state.
  always_comb begin
    rdata_o = stored_data_s;
    rpend_o = stored_pend_s;
  end
`endif

endmodule

// File: rtl/rf_multiport_sb.sv
// Two-write, NUM_RD-read register file with integrated pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is built when RF_BYPASS_EN is defined.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = RF_ZERO_REG,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*ADDR_W-1:0] RAddr,
  output logic [NUM_RD*DATA_W-1:0] RData,
  output logic [NUM_RD-1:0]        RPend,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WAddr0,
  input  logic [DATA_W-1:0]        WData0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WAddr1,
  input  logic [DATA_W-1:0]        WData1,
  input  logic                     AllocEn,
  input  logic [ADDR_W-1:0]        AllocAddr,
  output logic [NUM_REGS-1:0]      PendVec,
  output logic                     WrConflict
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic                conflict_q;
  logic                conflict_d;
  logic                wr0_live_s;
  logic                wr1_live_s;
  logic                alloc_live_s;

  // Qualify each request against XZR and unmapped indices.
  always_comb begin
    wr0_live_s   = WE0 && idx_live(int'(WAddr0), NUM_REGS, ZERO_REG);
    wr1_live_s   = WE1 && idx_live(int'(WAddr1), NUM_REGS, ZERO_REG);
    alloc_live_s = AllocEn && idx_live(int'(AllocAddr), NUM_REGS, ZERO_REG);
    conflict_d   = wr0_live_s && wr1_live_s && (WAddr0 == WAddr1);
  end

  // Next state per register: load port beats ALU port; a new alloc beats a retiring write.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (wr1_live_s && (WAddr1 == ADDR_W'(i))) ? WData1 :
                  ((wr0_live_s && (WAddr0 == ADDR_W'(i))) ? WData0 : regs_q[i]);
      pend_d[i] = (alloc_live_s && (AllocAddr == ADDR_W'(i))) ? 1'b1 :
                  (((wr0_live_s && (WAddr0 == ADDR_W'(i))) ||
                    (wr1_live_s && (WAddr1 == ADDR_W'(i)))) ? 1'b0 : pend_q[i]);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      pend_q     <= {NUM_REGS{1'b0}};
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q     <= pend_d;
      conflict_q <= conflict_d;
    end
  end

  assign PendVec    = pend_q;
  assign WrConflict = conflict_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .raddr_i      (RAddr[k*ADDR_W +: ADDR_W]),
      .regs_i       (regs_q),
      .pend_i       (pend_q),
`ifdef RF_BYPASS_EN
      .we0_i        (WE0),
      .waddr0_i     (WAddr0),
      .wdata0_i     (WData0),
      .we1_i        (WE1),
      .waddr1_i     (WAddr1),
      .wdata1_i     (WData1),
      .alloc_en_i   (AllocEn),
      .alloc_addr_i (AllocAddr),
`endif
      .rdata_o      (RData[k*DATA_W +: DATA_W]),
      .rpend_o      (RPend[k])
    );
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb: directed steps then randomized traffic
// compared against an array-based reference model.
module tb_rf_multiport_sb;
  import rf_pkg::*;

  localparam int NR  = 32;
  localparam int DW  = 64;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int ZR  = 31;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NRD*AW-1:0] RAddr;
  logic [NRD*DW-1:0] RData;
  logic [NRD-1:0]    RPend;
  logic              WE0, WE1, AllocEn;
  logic [AW-1:0]     WAddr0, WAddr1, AllocAddr;
  logic [DW-1:0]     WData0, WData1;
  logic [NR-1:0]     PendVec;
  logic              WrConflict;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_pend;
  logic          m_conf;

  always #5 Clk = ~Clk;

  rf_multiport_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(ZR)) dut (
    .Clk(Clk), .Rst(Rst), .RAddr(RAddr), .RData(RData), .RPend(RPend),
    .WE0(WE0), .WAddr0(WAddr0), .WData0(WData0),
    .WE1(WE1), .WAddr1(WAddr1), .WData1(WData1),
    .AllocEn(AllocEn), .AllocAddr(AllocAddr),
    .PendVec(PendVec), .WrConflict(WrConflict)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit writable(input logic [AW-1:0] a);
    return (int'(a) < NR) && (int'(a) != ZR);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    if (!writable(a)) return '0;
`ifdef RF_BYPASS_EN
    if (WE1 && WAddr1 == a) return WData1;
    if (WE0 && WAddr0 == a) return WData0;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_rpend(input logic [AW-1:0] a);
    if (!writable(a)) return 1'b0;
`ifdef RF_BYPASS_EN
    if ((WE1 && WAddr1 == a) || (WE0 && WAddr0 == a)) return AllocEn && (AllocAddr == a);
`endif
    return m_pend[a];
  endfunction

  // Apply the architectural effect of one clock edge to the model.
  task automatic model_edge();
    bit v0, v1;
    if (!Rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_pend = '0;
      m_conf = 1'b0;
    end else begin
      v0 = WE0 && writable(WAddr0);
      v1 = WE1 && writable(WAddr1);
      if (v0) m_regs[WAddr0] = WData0;
      if (v1) m_regs[WAddr1] = WData1;
      if (v0) m_pend[WAddr0] = 1'b0;
      if (v1) m_pend[WAddr1] = 1'b0;
      if (AllocEn && writable(AllocAddr)) m_pend[AllocAddr] = 1'b1;
      m_conf = v0 && v1 && (WAddr0 == WAddr1);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("pendvec", PendVec, m_pend);
    chk("wrconflict", WrConflict, m_conf);
  endtask

  task automatic check_reads(input string tag);
    logic [AW-1:0] a;
    #1;
    for (int k = 0; k < NRD; k++) begin
      a = RAddr[k*AW +: AW];
      chk($sformatf("%s rdata%0d a=%0d", tag, k, a), RData[k*DW +: DW], exp_rdata(a));
      chk($sformatf("%s rpend%0d a=%0d", tag, k, a), RPend[k], exp_rpend(a));
    end
  endtask

  task automatic idle();
    WE0 = 1'b0; WE1 = 1'b0; AllocEn = 1'b0;
    WAddr0 = '0; WAddr1 = '0; AllocAddr = '0;
    WData0 = '0; WData1 = '0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NR - 1));
  endfunction

  task automatic rand_traffic();
    wb_port_t w0, w1;
    w0.we = 1'($urandom_range(0, 1)); w0.addr = pick_addr(); w0.data = {$urandom, $urandom};
    w1.we = 1'($urandom_range(0, 1)); w1.addr = pick_addr(); w1.data = {$urandom, $urandom};
    WE0 = w0.we; WAddr0 = w0.addr; WData0 = w0.data;
    WE1 = w1.we; WAddr1 = w1.addr; WData1 = w1.data;
    AllocEn = 1'($urandom_range(0, 1)); AllocAddr = pick_addr();
    for (int k = 0; k < NRD; k++) RAddr[k*AW +: AW] = pick_addr();
  endtask

  initial begin
    Rst = 1'b0; RAddr = '0; idle();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_pend = '0; m_conf = 1'b0;
    step(); step();
    Rst = 1'b1;

    // Reset: populate state, then reset while traffic is still active.
    for (int c = 0; c < 6; c++) begin rand_traffic(); step(); end
    rand_traffic(); Rst = 1'b0; step();
    Rst = 1'b1; idle();
    chk("reset pendvec", PendVec, 64'd0);
    chk("reset wrconflict", WrConflict, 64'd0);
    for (int a = 0; a < NR; a++) begin
      RAddr[0 +: AW] = AW'(a); RAddr[AW +: AW] = AW'(NR - 1 - a);
      #1;
      chk($sformatf("reset rdata0 a=%0d", a), RData[0 +: DW], 64'd0);
      chk($sformatf("reset rdata1 a=%0d", a), RData[DW +: DW], 64'd0);
    end

    // Write then read; same-cycle read observes the pre-write value unless forwarding is built.
    WE0 = 1'b1; WAddr0 = 5'd5; WData0 = 64'hDEAD_BEEF; RAddr[0 +: AW] = 5'd5;
    check_reads("wr same-cycle");
`ifdef RF_BYPASS_EN
    chk("wr same-cycle const", RData[0 +: DW], 64'hDEAD_BEEF);
`else
    chk("wr same-cycle const", RData[0 +: DW], 64'd0);
`endif
    step(); idle();
    check_reads("wr next-cycle");
    chk("wr next-cycle const", RData[0 +: DW], 64'hDEAD_BEEF);

    // Zero register ignores writes and allocs.
    WE1 = 1'b1; WAddr1 = 5'd31; WData1 = 64'hFFFF; AllocEn = 1'b1; AllocAddr = 5'd31;
    RAddr[0 +: AW] = 5'd31;
    check_reads("xzr same");
    step(); idle();
    check_reads("xzr after");
    chk("xzr rdata", RData[0 +: DW], 64'd0);
    chk("xzr rpend", RPend[0], 64'd0);
    chk("xzr pendvec31", PendVec[31], 64'd0);

    // Write conflict: load port wins, one-cycle pulse.
    WE0 = 1'b1; WE1 = 1'b1; WAddr0 = 5'd7; WAddr1 = 5'd7; WData0 = 64'd1; WData1 = 64'd2;
    step(); idle();
    chk("conflict pulse", WrConflict, 64'd1);
    RAddr[0 +: AW] = 5'd7;
    check_reads("conflict read");
    chk("conflict winner", RData[0 +: DW], 64'd2);
    step();
    chk("conflict drop", WrConflict, 64'd0);

    // Scoreboard set / clear / set-wins.
    AllocEn = 1'b1; AllocAddr = 5'd3;
    step(); idle();
    chk("sb alloc", PendVec[3], 64'd1);
    RAddr[AW +: AW] = 5'd3;
    check_reads("sb read");
    chk("sb rpend1", RPend[1], 64'd1);
    WE1 = 1'b1; WAddr1 = 5'd3; WData1 = 64'h33;
    step(); idle();
    chk("sb clear", PendVec[3], 64'd0);
    AllocEn = 1'b1; AllocAddr = 5'd3; WE0 = 1'b1; WAddr0 = 5'd3; WData0 = 64'h44;
    step(); idle();
    chk("sb set wins", PendVec[3], 64'd1);

    // Same-cycle write and read of register 9 from port 1.
    WE0 = 1'b1; WAddr0 = 5'd9; WData0 = 64'h1234; RAddr[AW +: AW] = 5'd9;
    check_reads("bypass");
`ifdef RF_BYPASS_EN
    chk("bypass rdata1", RData[DW +: DW], 64'h1234);
    chk("bypass rpend1", RPend[1], 64'd0);
`endif
    step(); idle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rand_traffic();
      Rst = ($urandom_range(0, 63) != 0);
      check_reads("rand");
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
